// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryptor: one round per clock; done rises W+11 cycles after the load edge (W = KEYWAIT cycles).
// A load is taken only in IDLE/DONE; the round keys come back combinationally for the registered round_idx.

module aes_sbox (
    input  logic [7:0] val,
    output logic [7:0] sub
);
    localparam logic [0:255][7:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign sub = TABLE[val];
endmodule

module aes_cipher_core #(
    parameter int NR = 10
) (
    input  logic         int_osc,
    input  logic         reset,
    input  logic         load,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         key_load,
    input  logic         key_done,
    output logic [3:0]   round_idx,
    input  logic [127:0] round_key,
    output logic [127:0] cyphertext,
    output logic         done,
    output logic         busy
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        KEYWAIT = 3'd1,
        ROUND0  = 3'd2,
        ROUNDS  = 3'd3,
        FINAL   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t       state, state_nxt;
    logic [127:0] state_reg;
    logic [127:0] sub, shifted, mixed;
    logic [3:0]   rnd;
    logic         accept;

    // The key feeds the expansion block directly; this core only sees round keys.
    logic key_unused;
    assign key_unused = ^key;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (
            .val (state_reg[127-8*i -: 8]),
            .sub (sub[127-8*i -: 8])
        );
    end

    // Byte 4*c+r sits at row r, column c; row r rotates left by r columns.
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127-8*(4*c+r) -: 8] = sub[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    end

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = mix_col(shifted[127-32*c -: 32]);
        end
    end

    assign accept = ((state == IDLE) || (state == DONE)) && load;

    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    if (load) state_nxt = KEYWAIT;
            KEYWAIT: begin
                busy = 1'b1;
                if (key_done) state_nxt = ROUND0;
            end
            ROUND0:  begin
                busy      = 1'b1;
                state_nxt = ROUNDS;
            end
            ROUNDS:  begin
                busy = 1'b1;
                if (rnd == 4'(NR - 1)) state_nxt = FINAL;
            end
            FINAL:   begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE:    begin
                done = 1'b1;
                if (load) state_nxt = KEYWAIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // round_idx tracks the value rnd takes next, so the key is ready at cycle start.
    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            state_reg  <= '0;
            cyphertext <= '0;
            rnd        <= '0;
            round_idx  <= '0;
            key_load   <= 1'b0;
        end else begin
            key_load <= accept;
            case (state)
                IDLE, DONE: begin
                    if (load) begin
                        state_reg <= plaintext;
                        rnd       <= '0;
                        round_idx <= '0;
                    end
                end
                ROUND0: begin
                    state_reg <= state_reg ^ round_key;
                    rnd       <= 4'd1;
                    round_idx <= 4'd1;
                end
                ROUNDS: begin
                    state_reg <= mixed ^ round_key;
                    rnd       <= rnd + 4'd1;
                    round_idx <= rnd + 4'd1;
                end
                FINAL:   cyphertext <= shifted ^ round_key;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_cipher_core.sv
// Scoreboarded bench for aes_cipher_core with a behavioural key-expansion stage.
// FIPS-197 vectors, latency/round_idx timing, ignored loads, mid-run reset, back-to-back loads.

module tb_aes_cipher_core;
    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         int_osc = 1'b0;
    logic         reset, load, key_done, key_load, done, busy;
    logic [127:0] plaintext, key, round_key, cyphertext;
    logic [3:0]   round_idx;

    logic         kd_model = 1'b0;
    logic         kd_force = 1'b0;
    int           kd_delay = 1;
    logic [127:0] rk [0:10];
    logic [127:0] exp_q [$];
    logic [3:0]   trace [$];
    int           checks = 0;
    int           errors = 0;
    int           kl_count = 0;
    logic         prev_done = 1'b0;

    aes_cipher_core dut (
        .int_osc    (int_osc),
        .reset      (reset),
        .load       (load),
        .plaintext  (plaintext),
        .key        (key),
        .key_load   (key_load),
        .key_done   (key_done),
        .round_idx  (round_idx),
        .round_key  (round_key),
        .cyphertext (cyphertext),
        .done       (done),
        .busy       (busy)
    );

    always #5 int_osc = ~int_osc;

    assign key_done = kd_model | kd_force;
    always_comb round_key = (round_idx <= 4'd10) ? rk[round_idx] : '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from the field inverse plus affine map, independent of any table.
    function automatic logic [7:0] sbox_f(input logic [7:0] v);
        logic [7:0] inv;
        inv = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (gmul(v, 8'(c)) == 8'h01) inv = 8'(c);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic expand_key(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_f(t[31:24]), sbox_f(t[23:16]), sbox_f(t[15:8]), sbox_f(t[7:0])}
                    ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Key-expansion stand-in: key_done is high in the cycle kd_delay cycles after key_load.
    initial begin
        forever begin
            @(negedge int_osc);
            if (key_load === 1'b1) begin
                expand_key(key);
                repeat (kd_delay) @(negedge int_osc);
                kd_model = 1'b1;
                @(negedge int_osc);
                kd_model = 1'b0;
            end
        end
    end

    // Monitor: pops one expected ciphertext on each rising edge of done.
    always @(negedge int_osc) begin
        if (key_load === 1'b1) kl_count++;
        if (busy === 1'b1 && (trace.size() == 0 || trace[$] != round_idx)) trace.push_back(round_idx);
        if (done === 1'b1 && prev_done !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                check("ciphertext", cyphertext, exp_q.pop_front());
            end
        end
        prev_done = done;
    end

    task automatic run_op(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] ct,
                          input int kd, input bit mid_load, input bit b2b, input bit chk_trace);
        int lat;
        int kl0;
        logic [127:0] prev_ct;
        lat       = 0;
        plaintext = pt;
        key       = k;
        kd_delay  = kd;
        prev_ct   = cyphertext;
        kl0       = kl_count;
        trace.delete();
        exp_q.push_back(ct);
        load     = 1'b1;
        kd_force = b2b;
        @(negedge int_osc);
        load     = 1'b0;
        kd_force = 1'b0;
        if (b2b) begin
            check("done_drop", {127'd0, done}, 128'd0);
            check("ct_hold", cyphertext, prev_ct);
        end
        for (int j = 1; j <= 100; j++) begin
            @(negedge int_osc);
            load = 1'b0;
            if (mid_load && j == kd + 6) begin
                check("busy_mid", {127'd0, busy}, 128'd1);
                load = 1'b1;
            end
            if (done === 1'b1) begin
                lat = j;
                break;
            end
        end
        load = 1'b0;
        check("latency", 128'(lat), 128'(12 + kd));
        check("key_load_pulses", 128'(kl_count - kl0), 128'd1);
        if (chk_trace) begin
            check("trace_len", 128'(trace.size()), 128'd11);
            for (int i = 0; i < trace.size() && i < 11; i++) begin
                check("round_idx_step", {124'd0, trace[i]}, 128'(i));
            end
        end
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        reset     = 1'b0;
        load      = 1'b0;
        plaintext = '0;
        key       = '0;
        for (int r = 0; r < 11; r++) rk[r] = '0;
        repeat (2) @(negedge int_osc);
        check("rst_done", {127'd0, done}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_key_load", {127'd0, key_load}, 128'd0);
        check("rst_round_idx", {124'd0, round_idx}, 128'd0);
        check("rst_ct", cyphertext, 128'd0);
        reset = 1'b1;
        repeat (2) @(negedge int_osc);

        run_op(PT1, K1, CT1, 2, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge int_osc);
        run_op(PT1, K1, CT1, 5, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge int_osc);
        run_op(PT1, K1, CT1, 3, 1'b1, 1'b0, 1'b0);

        // Abandon an operation mid-round with reset.
        repeat (2) @(negedge int_osc);
        plaintext = PT2;
        key       = K2;
        kd_delay  = 2;
        exp_q.push_back(CT2);
        load = 1'b1;
        @(negedge int_osc);
        load = 1'b0;
        repeat (7) @(negedge int_osc);
        check("busy_before_reset", {127'd0, busy}, 128'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", {127'd0, busy}, 128'd0);
        check("arst_done", {127'd0, done}, 128'd0);
        check("arst_key_load", {127'd0, key_load}, 128'd0);
        check("arst_ct", cyphertext, 128'd0);
        void'(exp_q.pop_back());
        repeat (2) @(negedge int_osc);
        reset = 1'b1;
        repeat (3) @(negedge int_osc);
        check("post_reset_idle", {126'd0, done, busy}, 128'd0);

        run_op(PT1, K1, CT1, 1, 1'b0, 1'b0, 1'b0);
        run_op(PT2, K2, CT2, 4, 1'b0, 1'b1, 1'b0);

        repeat (3) @(negedge int_osc);
        check("scoreboard_drain", 128'(exp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
